// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_data_sampler.sv
// Per-bit oversampling counter with a 3-sample majority vote around the bit centre.
module data_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rx_in,
  output logic sampled_bit,
  output logic sample_done,
  output logic bit_end
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] S0_AT   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] S1_AT   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] S2_AT   = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] VOTE_AT = CW'(PRESCALE / 2 + 2);
  localparam logic [CW-1:0] LAST_AT = CW'(PRESCALE - 1);

  logic [CW-1:0] edge_cnt;
  logic [2:0]    samples;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      samples  <= '0;
    end else begin
      if (!en || edge_cnt == LAST_AT) edge_cnt <= '0;
      else                            edge_cnt <= edge_cnt + 1'b1;
      if (en && edge_cnt == S0_AT) samples[0] <= rx_in;
      if (en && edge_cnt == S1_AT) samples[1] <= rx_in;
      if (en && edge_cnt == S2_AT) samples[2] <= rx_in;
    end
  end

  // Samples stay stable until the next bit's first sample, so the vote is valid through bit_end.
  assign sampled_bit = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
  assign sample_done = en && (edge_cnt == VOTE_AT);
  assign bit_end     = en && (edge_cnt == LAST_AT);
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first data, optional parity, one stop bit.
// Good words land on p_data with a 1-cycle data_valid; bad frames raise par_err or stop_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  output logic [DWIDTH-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);
  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

  rx_state_t         state, next_state;
  logic [BW-1:0]     bit_cnt;
  logic [DWIDTH-1:0] shift_reg;
  logic              par_en_q, par_typ_q, par_bad;
  logic              sampled_bit, sample_done, bit_end;
  logic              exp_par;

  data_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .en          (state != IDLE),
    .rx_in       (rx_in),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done),
    .bit_end     (bit_end)
  );

  assign exp_par = (par_typ_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_in) next_state = START;
      START:   if (bit_end) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        IDLE: if (!rx_in) begin
          par_en_q  <= par_en;
          par_typ_q <= par_typ;
          par_bad   <= 1'b0;
          bit_cnt   <= '0;
        end
        DATA: begin
          if (sample_done) shift_reg[bit_cnt] <= sampled_bit;
          if (bit_end && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (sample_done) par_bad <= (sampled_bit != exp_par);
        // A bad stop bit outranks a parity mismatch; only clean frames touch p_data.
        STOP: if (bit_end) begin
          if (!sampled_bit)  stop_err <= 1'b1;
          else if (par_bad)  par_err  <= 1'b1;
          else begin
            p_data     <= shift_reg;
            data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DWIDTH=8, PRESCALE=8.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stop_err;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;
  int serr_cnt = 0;
  int wide_cnt = 0;
  int excl_cnt = 0;
  logic strobe_prev = 1'b0;
  logic [DW-1:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DWIDTH(DW), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      rx_q.push_back(p_data);
    end
    if (par_err) perr_cnt++;
    if (stop_err) serr_cnt++;
    if ((data_valid + par_err + stop_err) > 2'd1) excl_cnt++;
    if ((data_valid | par_err | stop_err) && strobe_prev) wide_cnt++;
    strobe_prev = data_valid | par_err | stop_err;
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (PS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic with_par,
                            input logic pbit, input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (with_par) drive_bit(pbit);
    drive_bit(sbit);
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
    checks++; if (stop_err !== 1'b0) begin errors++; $display("FAIL reset_stop_err: got %b expected 0", stop_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_no_parity();
    int v0, e0;
    v0 = valid_cnt; e0 = perr_cnt + serr_cnt;
    par_en = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(3);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL a5_valid_count: got %0d expected %0d", valid_cnt - v0, 1); end
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL a5_p_data: got %h expected a5", p_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", busy); end
    checks++; if (perr_cnt + serr_cnt !== e0) begin errors++; $display("FAIL a5_no_err: got %0d expected 0", perr_cnt + serr_cnt - e0); end
  endtask

  task automatic test_parity_even();
    int v0, p0;
    par_en = 1'b1; par_typ = 1'b0;
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(3);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL even_good_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL even_good_p_data: got %h expected 3c", p_data); end
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(3);
    checks++; if (perr_cnt !== p0 + 1) begin errors++; $display("FAIL even_bad_par_err: got %0d expected 1", perr_cnt - p0); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL even_bad_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL even_bad_p_data_held: got %h expected 3c", p_data); end
  endtask

  task automatic test_parity_odd_stop();
    int v0, p0, s0;
    par_en = 1'b1; par_typ = 1'b1;
    v0 = valid_cnt;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    idle(3);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL odd_good_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (p_data !== 8'h01) begin errors++; $display("FAIL odd_good_p_data: got %h expected 01", p_data); end
    v0 = valid_cnt; p0 = perr_cnt; s0 = serr_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    idle(3);
    checks++; if (serr_cnt !== s0 + 1) begin errors++; $display("FAIL stop_err_raised: got %0d expected 1", serr_cnt - s0); end
    checks++; if (perr_cnt !== p0) begin errors++; $display("FAIL stop_err_priority: got %0d par_err expected 0", perr_cnt - p0); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL stop_err_no_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (p_data !== 8'h01) begin errors++; $display("FAIL stop_err_p_data_held: got %h expected 01", p_data); end
  endtask

  task automatic test_glitch();
    int t0;
    par_en = 1'b0;
    t0 = valid_cnt + perr_cnt + serr_cnt;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    repeat (10) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %b expected 0", busy); end
    checks++; if (valid_cnt + perr_cnt + serr_cnt !== t0) begin errors++; $display("FAIL glitch_no_strobe: got %0d expected 0", valid_cnt + perr_cnt + serr_cnt - t0); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got0, got1;
    par_en = 1'b0;
    rx_q.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    idle(3);
    got0 = (rx_q.size() > 0) ? rx_q[0] : 'x;
    got1 = (rx_q.size() > 1) ? rx_q[1] : 'x;
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size()); end
    checks++; if (got0 !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h expected 55", got0); end
    checks++; if (got1 !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h expected aa", got1); end
  endtask

  task automatic test_reset_mid_frame();
    int t0, v0;
    logic [DW-1:0] d;
    d = 8'h5A;
    par_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (4) @(negedge clk);
    t0 = valid_cnt + perr_cnt + serr_cnt;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL midrst_p_data: got %h expected 00", p_data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_data_valid: got %b expected 0", data_valid); end
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(30);
    checks++; if (valid_cnt + perr_cnt + serr_cnt !== t0) begin errors++; $display("FAIL midrst_no_strobe: got %0d expected 0", valid_cnt + perr_cnt + serr_cnt - t0); end
    v0 = valid_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    idle(3);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL after_rst_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (p_data !== 8'h0F) begin errors++; $display("FAIL after_rst_p_data: got %h expected 0f", p_data); end
  endtask

  task automatic test_strobe_shape();
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_one_cycle: got %0d wide pulses expected 0", wide_cnt); end
    checks++; if (excl_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", excl_cnt); end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity_even();
    test_parity_odd_stop();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_strobe_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
